// File: rtl/btn_clk_gen.sv
// Multi-channel programmable divided-clock / tick generator.
// Config writes stage into pending registers and are applied only on a period boundary.
module btn_clk_gen #(
    parameter int CLK_FREQ     = 100000000,
    parameter int DEFAULT_FREQ = 320,
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int CH_W         = 2
) (
    input  logic              Clk_In,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [1:0]        cfg_mode,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        MODE_SQUARE  = 2'b00,
        MODE_TICK    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam longint unsigned LP_RATIO    = longint'(CLK_FREQ / DEFAULT_FREQ);
    localparam logic [CNT_W-1:0] LP_DEF_DIV  = LP_RATIO[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LP_DEF_HIGH = LP_DEF_DIV >> 1;
    localparam logic [CH_W:0]    LP_NUM_CH   = (CH_W+1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_chk_nch
        $error("btn_clk_gen: NUM_CH must be in 1..16");
    end
    if ((2 ** CH_W) < NUM_CH) begin : g_chk_chw
        $error("btn_clk_gen: CH_W too narrow for NUM_CH");
    end
    if ((LP_RATIO >> CNT_W) != 0 || LP_RATIO < 2) begin : g_chk_div
        $error("btn_clk_gen: CLK_FREQ/DEFAULT_FREQ must fit CNT_W bits and be >= 2");
    end

    logic w_cfg_bad;
    logic w_cfg_ok;
    logic r_cfg_err;

    assign w_cfg_bad = ({1'b0, cfg_ch} >= LP_NUM_CH) || (cfg_div < CNT_W'(2)) ||
                       (mode_e'(cfg_mode) == MODE_RSVD);
    assign w_cfg_ok  = cfg_we && !w_cfg_bad;

    always_ff @(posedge Clk_In or negedge rst) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && w_cfg_bad;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_high;
        mode_e            r_mode;
        logic [CNT_W-1:0] r_pdiv;
        logic [CNT_W-1:0] r_phigh;
        mode_e            r_pmode;
        logic             r_pvalid;
        logic             r_done;
        logic             r_clk;
        logic             r_tick;

        logic             w_sel;
        logic             w_run;
        logic             w_wrap;
        logic             w_apply;
        logic [CNT_W-1:0] w_cn;
        logic [CNT_W-1:0] w_high_eff;
        mode_e            w_mode_eff;
        logic             w_clk_nxt;

        assign w_sel = w_cfg_ok && (cfg_ch == CH_W'(g));

        // The first cycle of a new period already uses the config applied at its wrap
        always_comb begin
            w_run      = en[g] && !r_done && !sync_clr;
            w_wrap     = w_run && (r_count == r_div - CNT_W'(1));
            w_apply    = r_pvalid && (w_wrap || !en[g] || sync_clr);
            w_cn       = w_wrap ? '0 : r_count + CNT_W'(1);
            w_high_eff = w_apply ? r_phigh : r_high;
            w_mode_eff = w_apply ? r_pmode : r_mode;
            w_clk_nxt  = 1'b0;
            unique case (w_mode_eff)
                MODE_SQUARE:  w_clk_nxt = (w_cn < w_high_eff);
                MODE_TICK:    w_clk_nxt = w_wrap;
                MODE_ONESHOT: w_clk_nxt = (w_cn < w_high_eff) && !w_wrap;
                default:      w_clk_nxt = 1'b0;
            endcase
        end

        always_ff @(posedge Clk_In or negedge rst) begin
            if (!rst) begin
                r_count  <= '0;
                r_div    <= LP_DEF_DIV;
                r_high   <= LP_DEF_HIGH;
                r_mode   <= MODE_SQUARE;
                r_pdiv   <= LP_DEF_DIV;
                r_phigh  <= LP_DEF_HIGH;
                r_pmode  <= MODE_SQUARE;
                r_pvalid <= 1'b0;
                r_done   <= 1'b0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_div  <= r_pdiv;
                    r_high <= r_phigh;
                    r_mode <= r_pmode;
                end

                // A write landing on an apply edge refills pending for the next boundary
                if (w_sel) begin
                    r_pdiv   <= cfg_div;
                    r_phigh  <= cfg_high;
                    r_pmode  <= mode_e'(cfg_mode);
                    r_pvalid <= 1'b1;
                end else if (w_apply) begin
                    r_pvalid <= 1'b0;
                end

                if (!w_run) begin
                    r_count <= '0;
                    r_clk   <= 1'b0;
                    r_tick  <= 1'b0;
                    r_done  <= r_done && en[g] && !sync_clr;
                end else begin
                    r_count <= w_cn;
                    r_clk   <= w_clk_nxt;
                    r_tick  <= w_wrap;
                    r_done  <= w_wrap && (r_mode == MODE_ONESHOT) && !w_apply;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
    end

endmodule

// File: tb/tb_btn_clk_gen.sv
// Self-checking bench for btn_clk_gen: vector table plus hand sequences, scoreboard-compared.
module tb_btn_clk_gen;

    localparam int NCH = 4;
    localparam int CW  = 27;
    localparam int CHW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  en = '0;
    logic            sync_clr = 1'b0;
    logic            cfg_we = 1'b0;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [CW-1:0]   cfg_div = '0;
    logic [CW-1:0]   cfg_high = '0;
    logic [1:0]      cfg_mode = '0;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;
    logic            cfg_err;

    btn_clk_gen #(
        .CLK_FREQ(1000),
        .DEFAULT_FREQ(100),
        .NUM_CH(NCH),
        .CNT_W(CW),
        .CH_W(CHW)
    ) dut (
        .Clk_In(clk),
        .rst(rst),
        .en(en),
        .sync_clr(sync_clr),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_high(cfg_high),
        .cfg_mode(cfg_mode),
        .clk_out(clk_out),
        .tick(tick),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] en;
        logic           sclr;
        logic           we;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  div;
        logic [CW-1:0]  high;
        logic [1:0]     mode;
        logic [NCH-1:0] eclk;
        logic [NCH-1:0] etick;
        logic           eerr;
        string          nm;
    } vec_t;

    typedef struct {
        logic [NCH-1:0] eclk;
        logic [NCH-1:0] etick;
        logic           eerr;
        string          nm;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [1:0]     e1, e2;
    logic [NCH-1:0] xc, xt;

    function automatic vec_t mk(input logic [NCH-1:0] en_i, input logic sclr_i, input logic we_i,
                                input int ch_i, input int div_i, input int high_i, input int mode_i,
                                input logic [NCH-1:0] eclk_i, input logic [NCH-1:0] etick_i,
                                input logic eerr_i, input string nm_i);
        vec_t v;
        v.en = en_i; v.sclr = sclr_i; v.we = we_i;
        v.ch = CHW'(ch_i); v.div = CW'(div_i); v.high = CW'(high_i); v.mode = 2'(mode_i);
        v.eclk = eclk_i; v.etick = etick_i; v.eerr = eerr_i; v.nm = nm_i;
        return v;
    endfunction

    function automatic vec_t idle(input logic [NCH-1:0] en_i, input logic [NCH-1:0] eclk_i,
                                  input logic [NCH-1:0] etick_i, input string nm_i);
        return mk(en_i, 1'b0, 1'b0, 0, 0, 0, 0, eclk_i, etick_i, 1'b0, nm_i);
    endfunction

    // Square-mode expectation k edges into a period run: {clk_out, tick}
    function automatic logic [1:0] sq(input int k, input int d, input int h);
        int m;
        m = k % d;
        return {(m < h), (m == 0)};
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry, got clk_out=%b tick=%b cfg_err=%b",
                     clk_out, tick, cfg_err);
            return;
        end
        e = sb_q.pop_front();
        if (clk_out !== e.eclk || tick !== e.etick || cfg_err !== e.eerr) begin
            errors++;
            $display("FAIL %s: got clk_out=%b tick=%b cfg_err=%b, expected clk_out=%b tick=%b cfg_err=%b",
                     e.nm, clk_out, tick, cfg_err, e.eclk, e.etick, e.eerr);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        en = v.en; sync_clr = v.sclr; cfg_we = v.we; cfg_ch = v.ch;
        cfg_div = v.div; cfg_high = v.high; cfg_mode = v.mode;
        e.eclk = v.eclk; e.etick = v.etick; e.eerr = v.eerr; e.nm = v.nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic expect_now(input logic [NCH-1:0] eclk_i, input logic [NCH-1:0] etick_i,
                              input logic eerr_i, input string nm_i);
        exp_t e;
        e.eclk = eclk_i; e.etick = etick_i; e.eerr = eerr_i; e.nm = nm_i;
        sb_q.push_back(e);
        check_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ch1 div=4 high=1 and ch0 div=2 tick-only (boundary div), with rejected writes in between
        tbl.push_back(mk(4'b0000, 0, 1, 1, 4, 1, 0, 4'b0000, 4'b0000, 0, "ch1_write"));
        tbl.push_back(idle(4'b0000, 4'b0000, 4'b0000, "ch1_apply"));
        tbl.push_back(mk(4'b0000, 0, 1, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, "err_div1"));
        tbl.push_back(idle(4'b0000, 4'b0000, 4'b0000, "err_drop1"));
        tbl.push_back(mk(4'b0000, 0, 1, 5, 8, 2, 0, 4'b0000, 4'b0000, 1, "err_ch5"));
        tbl.push_back(mk(4'b0000, 0, 1, 1, 7, 3, 3, 4'b0000, 4'b0000, 1, "err_mode11"));
        tbl.push_back(mk(4'b0000, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, "err_div0"));
        tbl.push_back(idle(4'b0000, 4'b0000, 4'b0000, "err_drop2"));
        tbl.push_back(mk(4'b0000, 0, 1, 0, 2, 2, 1, 4'b0000, 4'b0000, 0, "ch0_div2_ok"));
        tbl.push_back(idle(4'b0000, 4'b0000, 4'b0000, "ch0_apply"));
        for (int k = 1; k <= 8; k++) begin
            xc = '0; xt = '0;
            xc[0] = (k % 2 == 0); xt[0] = (k % 2 == 0);
            xc[1] = (k % 4 == 0); xt[1] = (k % 4 == 0);
            tbl.push_back(idle(4'b0011, xc, xt, "ch01_run"));
        end
        tbl.push_back(idle(4'b0000, 4'b0000, 4'b0000, "ch01_stop"));

        repeat (3) @(negedge clk);
        expect_now(4'b0000, 4'b0000, 1'b0, "reset_state");
        rst = 1'b1;

        for (int k = 1; k <= 25; k++) begin
            e1 = sq(k, 10, 5);
            apply_vec(idle(4'b0001, {3'b000, e1[1]}, {3'b000, e1[0]}, "ch0_default"));
        end
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch0_disable"));

        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

        // ch2: write landing on a wrap edge waits one full old period
        apply_vec(mk(4'b0000, 0, 1, 2, 5, 2, 0, 4'b0000, 4'b0000, 0, "ch2_write"));
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch2_apply"));
        for (int k = 1; k <= 19; k++) begin
            e1 = (k <= 10) ? sq(k, 5, 2) : sq(k - 10, 3, 1);
            xc = {1'b0, e1[1], 2'b00}; xt = {1'b0, e1[0], 2'b00};
            if (k == 5) apply_vec(mk(4'b0100, 0, 1, 2, 3, 1, 0, xc, xt, 0, "ch2_wrap_write"));
            else        apply_vec(idle(4'b0100, xc, xt, "ch2_run"));
        end
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch2_stop"));

        // ch3 one-shot, then retrigger by toggling en
        apply_vec(mk(4'b0000, 0, 1, 3, 6, 3, 2, 4'b0000, 4'b0000, 0, "ch3_write"));
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch3_apply"));
        for (int k = 1; k <= 12; k++)
            apply_vec(idle(4'b1000, {(k <= 2), 3'b000}, {(k == 6), 3'b000}, "ch3_oneshot"));
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch3_toggle"));
        for (int k = 1; k <= 6; k++)
            apply_vec(idle(4'b1000, {(k <= 2), 3'b000}, {(k == 6), 3'b000}, "ch3_retrig"));
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch3_stop"));

        // ch1 div=4, ch2 div=6 out of phase, then sync_clr realigns
        apply_vec(mk(4'b0000, 0, 1, 2, 6, 3, 0, 4'b0000, 4'b0000, 0, "ch2_div6_write"));
        apply_vec(idle(4'b0000, 4'b0000, 4'b0000, "ch2_div6_apply"));
        for (int k = 1; k <= 5; k++) begin
            e1 = sq(k, 4, 1);
            e2 = (k >= 3) ? sq(k - 2, 6, 3) : 2'b00;
            apply_vec(idle((k >= 3) ? 4'b0110 : 4'b0010, {1'b0, e2[1], e1[1], 1'b0},
                           {1'b0, e2[0], e1[0], 1'b0}, "pre_sync"));
        end
        apply_vec(mk(4'b0110, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, "sync_clr"));
        for (int k = 1; k <= 13; k++) begin
            e1 = sq(k, 4, 1);
            e2 = sq(k, 6, 3);
            apply_vec(idle(4'b0110, {1'b0, e2[1], e1[1], 1'b0}, {1'b0, e2[0], e1[0], 1'b0},
                           (k == 12) ? "sync_common_tick" : "post_sync"));
        end

        // Asynchronous reset mid-cycle, while ch2 clk_out is high; pending writes lost
        cfg_we = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        expect_now(4'b0000, 4'b0000, 1'b0, "async_reset");
        @(negedge clk);
        en = '0;
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            e1 = sq(k, 10, 5);
            apply_vec(idle(4'b0010, {2'b00, e1[1], 1'b0}, {2'b00, e1[0], 1'b0}, "ch1_after_reset"));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_clk_gen.md
Name: btn_clk_gen

Overview:
- Multi-channel programmable tick and clock generator, replacing the fixed single-frequency button/player-movement clock divider.
- Each channel derives a divided clock and a one-cycle tick from Clk_In. Divisor, high time and mode are runtime-configurable per channel.
- Config changes are glitch-free: they take effect only at a period boundary.
- Feeds player-movement, debounce-sampling and animation logic.

Parameters:
- CLK_FREQ, 100000000: Clk_In frequency in Hz.
- DEFAULT_FREQ, 320: reset-time output frequency of every channel, in Hz.
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 27: counter, divisor and high-time width in bits.
- CH_W, 2: channel-select width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- Clk_In  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset). Released synchronously by upstream.
- en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  restarts all channels in phase.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  CNT_W  period in Clk_In cycles.
- cfg_high  in  CNT_W  cycles of clk_out high per period.
- cfg_mode  in  2  00 square, 01 tick-only, 10 one-shot, 11 reserved.
- clk_out  out  NUM_CH  divided clock per channel (registered).
- tick  out  NUM_CH  one-cycle pulse per period (registered).
- cfg_err  out  1  one-cycle pulse on a rejected write (registered).

Behaviour:
- Reset values (rst=0):
  - count=0.
  - Active and pending div = CLK_FREQ/DEFAULT_FREQ (312500); high = div/2; mode = 00.
  - pend_valid=0; done=0; clk_out=0; tick=0; cfg_err=0.
- Per channel, on each edge with en=1, not done, sync_clr=0:
  - wrap = (count == div-1).
  - count <= wrap ? 0 : count+1; cn = that next count.
  - tick <= wrap.
  - clk_out <= mode 00: (cn < high); mode 01: wrap; mode 10: (cn < high) && !wrap.
- Timing rules:
  - Period is exactly div cycles.
  - First tick appears div cycles after en rises.
  - high=0 gives clk_out constant 0; high >= div gives constant 1 (mode 00).
- en=0: count <= 0, clk_out <= 0, tick <= 0, done <= 0; a pending config is applied on that edge.
- One-shot (mode 10): on the first wrap, set done. While done: count held at 0, clk_out=0, tick=0. done clears on en=0, sync_clr, or application of a new config.
- Config write (cfg_we=1):
  - Rejected (cfg_err <= 1, no state change) if cfg_ch >= NUM_CH, cfg_div < 2, or cfg_mode = 11.
  - Otherwise loads the channel's pending registers and sets pend_valid.
  - Pending is applied (pend_valid cleared) at the next edge where the channel wraps, is disabled, or sync_clr=1.
  - A write on the same edge as a wrap is NOT applied at that wrap; it waits for the following one.
  - Back-to-back writes to one channel: last write wins.
- sync_clr=1 (priority over counting; en=0 still dominates outputs):
  - All channels: count <= 0, tick <= 0, clk_out <= 0, done <= 0; pending applied.
  - Counting resumes on the next edge.
- Reset mid-operation: all state returns to reset values immediately; pending writes are lost.
- Widths:
  - count compares against div-1 in CNT_W bits with no overflow, since div >= 2.
  - CLK_FREQ/DEFAULT_FREQ must fit in CNT_W bits (elaboration check).

Test Plan:
- Reset release, en=1 on ch0, defaults -> first tick after 312500 cycles; clk_out high 156250 cycles per 312500-cycle period.
- ch1 write div=4, high=1, mode 00 while disabled, then en=1 -> clk_out 1,0,0,0 repeating; tick every 4th cycle, aligned to clk_out rise.
- ch2 running div=5; write div=3 on the wrap edge -> one more 5-cycle period, then 3-cycle periods; no runt pulse.
- ch3 mode 10, div=6, high=3 -> single tick 6 cycles after en; clk_out high 2 cycles; then silent until en toggles.
- Writes cfg_div=1, cfg_ch=5 (NUM_CH=4), cfg_mode=11 -> cfg_err pulses 1 cycle each; channel behaviour unchanged.
- Channels at div=4 and div=6 out of phase; sync_clr one cycle -> both counts 0; ticks coincide 4 and 6 cycles later (12-cycle common tick). rst=0 mid-run -> all outputs 0 asynchronously.
